mem_arb: RTL and testbench
==========================

# mem_arb

Two-port arbiter sharing the single DRAM controller read port between the instruction cache (`ic_*`) and data cache (`dc_*`) line-fill requesters. It accepts 128-bit line read requests from each cache and grants them round-robin into one registered downstream request slot. It tags each request with a source bit and routes DRAM responses back to the owning cache. Per-source credit counters bound the outstanding transactions so neither cache can exhaust the controller.

## Interface
- `MAX_OUT`, 4, max outstanding (issued, unanswered) requests per source; 1..15
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `ic_mem_addr`  in  23 [26:4]  IC line address
- `ic_mem_xid`  in  2  IC transaction id
- `ic_mem_re`  in  1  IC request valid
- `mem_ic_ready`  out  1  IC request accepted this cycle
- `mem_ic_valid`  out  1  IC response valid (one-cycle pulse)
- `mem_ic_xid`  out  2  IC response id
- `mem_ic_data`  out  128  IC response line
- `dc_mem_addr`, `dc_mem_xid`, `dc_mem_re`, `mem_dc_ready`, `mem_dc_valid`, `mem_dc_xid`, `mem_dc_data`: same directions, widths and meanings for the DC
- `arb_addr`  out  23  downstream line address
- `arb_xid`  out  3  downstream id = {src, xid}; src 0 = IC, 1 = DC
- `arb_re`  out  1  downstream request valid
- `dram_ready`  in  1  controller accepts `arb_*` this cycle
- `dram_valid`  in  1  controller response valid
- `dram_xid`  in  3  response id; bit 2 selects destination
- `dram_data`  in  128  response line
- `arb_err`  out  1  sticky: response arrived for a source with zero outstanding

## Operation
- Transfer on any port occurs at a rising edge where valid and ready are both high.
- Slot free = `!arb_re | dram_ready`.
- Source eligible = its `re` is high and its count < `MAX_OUT`.
- Grant:
  - One eligible source: it wins.
  - Both eligible: the source not granted last wins.
  - `last_grant` resets to DC, so IC wins the first tie.
- `mem_X_ready` = slot free & X granted. It is combinational from `re` inputs and registered state, never from `dram_*`. At most one ready is high per cycle.
- On accept: `arb_addr` and `arb_xid` load `{src, xid}`, `arb_re` sets, `last_grant` updates, and the source count increments.
- Slot free with no accept: `arb_re` clears.
- Slot not free: `arb_*` hold stable.
- Counters are $clog2(MAX_OUT+1) bits wide.
  - Decrement on `dram_valid` for that source.
  - Accept and response to the same source in the same cycle: net unchanged.
  - Response when the count is 0: count stays 0 and `arb_err` sets until reset.
- Response routing: `dram_valid` with `dram_xid[2]`=0 pulses `mem_ic_valid` and loads `mem_ic_xid`=`dram_xid[1:0]` and `mem_ic_data`=`dram_data`; `dram_xid[2]`=1 does the same on the DC port. The other port's valid stays 0, and data/xid registers load only on their own port's response.
- Responses carry no backpressure; the caches accept every response.

## Timing
- Reset (asynchronous, immediate): all outputs 0; counts 0; `last_grant`=DC; `arb_err`=0.
  - Reset asserted mid-transaction drops the pending `arb_re` and all credits; in-flight DRAM responses are the system's responsibility.
- Request latency: accepted at edge N, `arb_re` and payload visible after edge N. Each slot turn costs one cycle, so back-to-back accepts at full throughput are possible when `dram_ready`=1.
- `arb_*` are stable while `arb_re`=1 and `dram_ready`=0.
- Response latency: `dram_valid` at edge N; `mem_X_valid` high for exactly one cycle after edge N.
- A count change at edge N affects eligibility in the cycle after N.

## Test plan
- IC `re`=1, addr 0x12345, xid 2, `dram_ready`=1 → `mem_ic_ready`=1 that cycle; next cycle `arb_re`=1, `arb_addr`=0x12345, `arb_xid`=3'b010.
- Both requesters hold `re` for 4 cycles from reset, `dram_ready`=1 → grants IC, DC, IC, DC; `arb_xid[2]` = 0, 1, 0, 1.
- `dram_ready`=0 for 3 cycles with the slot full → `arb_*` unchanged and both readies 0; release → next accept on the following cycle.
- IC issues 4 requests with no responses (`MAX_OUT`=4) → 5th request not ready while DC is still granted. `dram_valid` with xid 3'b001 → IC ready returns the cycle after.
- `dram_valid` with xid 3'b101, data 0xA5…A5 → `mem_dc_valid`=1, `mem_dc_xid`=1, data matches next cycle; `mem_ic_valid`=0. Same-cycle accept plus response for DC → count unchanged.
- Response xid 3'b000 with IC count 0 → `arb_err`=1 and sticky. Assert `rst_n` low mid-stall → all outputs 0 immediately and `arb_err` cleared.

Source files
------------

// File: rtl/mem_arb_if.sv
// mem_arb_if: one cache line-fill port of the memory arbiter.
//   addr/xid/re : line read request from the cache (addr is line address [26:4])
//   ready       : arbiter accepted the request this cycle
//   rsp_valid   : one-cycle response pulse back to the cache
//   rsp_xid     : transaction id of the response
//   rsp_data    : 128-bit response line
// master = cache side, slave = arbiter side.
interface mem_arb_if;
  logic [22:0]  addr;
  logic [1:0]   xid;
  logic         re;
  logic         ready;
  logic         rsp_valid;
  logic [1:0]   rsp_xid;
  logic [127:0] rsp_data;

  modport master (
    output addr, xid, re,
    input  ready, rsp_valid, rsp_xid, rsp_data
  );

  modport slave (
    input  addr, xid, re,
    output ready, rsp_valid, rsp_xid, rsp_data
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one DRAM read port between the
// instruction cache (ic) and data cache (dc) line-fill requesters.
//   clk, rst_n        : clock, asynchronous active-low reset
//   ic, dc            : cache ports (request in, ready/response out)
//   arb_addr/xid/re   : registered downstream request slot, xid = {src, xid}
//   dram_ready        : controller accepts the slot this cycle
//   dram_valid/xid/data : controller response, dram_xid[2] selects the cache
//   arb_err           : sticky, response seen for a source with no credit used
// Per-source counters bound outstanding requests to MAX_OUT.
module mem_arb #(
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arb_if.slave     ic,
  mem_arb_if.slave     dc,
  output logic [22:0]  arb_addr,
  output logic [2:0]   arb_xid,
  output logic         arb_re,
  input  logic         dram_ready,
  input  logic         dram_valid,
  input  logic [2:0]   dram_xid,
  input  logic [127:0] dram_data,
  output logic         arb_err
);

  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } src_t;

  src_t          last_grant;
  logic [CW-1:0] cnt_ic;
  logic [CW-1:0] cnt_dc;

  logic slot_free;
  logic elig_ic;
  logic elig_dc;
  logic gnt_ic;
  logic gnt_dc;
  logic rsp_ic;
  logic rsp_dc;
  logic err_ic;
  logic err_dc;

  // A stray response (count already 0) is dropped; an accept in the same
  // cycle still takes its credit so the bound is never exceeded.
  function automatic logic [CW-1:0] cnt_next(
    input logic [CW-1:0] cnt,
    input logic          acc,
    input logic          rsp
  );
    logic dec;
    dec = rsp && (cnt != '0);
    case ({acc, dec})
      2'b10:   cnt_next = cnt + 1'b1;
      2'b01:   cnt_next = cnt - 1'b1;
      default: cnt_next = cnt;
    endcase
  endfunction

  always_comb begin
    slot_free = !arb_re || dram_ready;
    elig_ic   = ic.re && (cnt_ic < CW'(MAX_OUT));
    elig_dc   = dc.re && (cnt_dc < CW'(MAX_OUT));
    // On a tie the source that did not win last time goes first.
    gnt_ic    = elig_ic && (!elig_dc || (last_grant == SRC_DC));
    gnt_dc    = elig_dc && !gnt_ic;
    rsp_ic    = dram_valid && !dram_xid[2];
    rsp_dc    = dram_valid && dram_xid[2];
    err_ic    = rsp_ic && (cnt_ic == '0);
    err_dc    = rsp_dc && (cnt_dc == '0);
  end

  assign ic.ready = slot_free && gnt_ic;
  assign dc.ready = slot_free && gnt_dc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_re     <= 1'b0;
      arb_addr   <= '0;
      arb_xid    <= '0;
      last_grant <= SRC_DC;
    end else if (ic.ready) begin
      arb_re     <= 1'b1;
      arb_addr   <= ic.addr;
      arb_xid    <= {1'b0, ic.xid};
      last_grant <= SRC_IC;
    end else if (dc.ready) begin
      arb_re     <= 1'b1;
      arb_addr   <= dc.addr;
      arb_xid    <= {1'b1, dc.xid};
      last_grant <= SRC_DC;
    end else if (slot_free) begin
      arb_re     <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ic  <= '0;
      cnt_dc  <= '0;
      arb_err <= 1'b0;
    end else begin
      cnt_ic <= cnt_next(cnt_ic, ic.ready, rsp_ic);
      cnt_dc <= cnt_next(cnt_dc, dc.ready, rsp_dc);
      if (err_ic || err_dc) begin
        arb_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic.rsp_valid <= 1'b0;
      ic.rsp_xid   <= '0;
      ic.rsp_data  <= '0;
      dc.rsp_valid <= 1'b0;
      dc.rsp_xid   <= '0;
      dc.rsp_data  <= '0;
    end else begin
      ic.rsp_valid <= rsp_ic;
      dc.rsp_valid <= rsp_dc;
      if (rsp_ic) begin
        ic.rsp_xid  <= dram_xid[1:0];
        ic.rsp_data <= dram_data;
      end
      if (rsp_dc) begin
        dc.rsp_xid  <= dram_xid[1:0];
        dc.rsp_data <= dram_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed vector table plus hand-written sequences for mem_arb
// (MAX_OUT = 4). Inputs change on the falling edge; readies are sampled
// just after, registered outputs just after the following rising edge.
module tb_mem_arb;

  logic         clk;
  logic         rst_n;
  logic [22:0]  arb_addr;
  logic [2:0]   arb_xid;
  logic         arb_re;
  logic         dram_ready;
  logic         dram_valid;
  logic [2:0]   dram_xid;
  logic [127:0] dram_data;
  logic         arb_err;

  mem_arb_if ic_bus ();
  mem_arb_if dc_bus ();

  mem_arb #(.MAX_OUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ic         (ic_bus),
    .dc         (dc_bus),
    .arb_addr   (arb_addr),
    .arb_xid    (arb_xid),
    .arb_re     (arb_re),
    .dram_ready (dram_ready),
    .dram_valid (dram_valid),
    .dram_xid   (dram_xid),
    .dram_data  (dram_data),
    .arb_err    (arb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] DATA_T = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] DATA_A = {4{32'hA5A5_A5A5}};

  typedef struct {
    logic        ic_re;
    logic [22:0] ic_addr;
    logic [1:0]  ic_xid;
    logic        dc_re;
    logic [22:0] dc_addr;
    logic [1:0]  dc_xid;
    logic        drdy;
    logic        dval;
    logic [2:0]  dxid;
    logic        e_icr;
    logic        e_dcr;
    logic        e_re;
    logic [22:0] e_addr;
    logic [2:0]  e_xid;
    logic        e_icv;
    logic        e_dcv;
  } vec_t;

  int checks = 0;
  int failures = 0;
  vec_t vt[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic ic_re, input logic [22:0] ic_addr, input logic [1:0] ic_xid,
    input logic dc_re, input logic [22:0] dc_addr, input logic [1:0] dc_xid,
    input logic drdy, input logic dval, input logic [2:0] dxid,
    input logic e_icr, input logic e_dcr,
    input logic e_re, input logic [22:0] e_addr, input logic [2:0] e_xid,
    input logic e_icv, input logic e_dcv);
    vec_t v;
    v.ic_re = ic_re; v.ic_addr = ic_addr; v.ic_xid = ic_xid;
    v.dc_re = dc_re; v.dc_addr = dc_addr; v.dc_xid = dc_xid;
    v.drdy = drdy; v.dval = dval; v.dxid = dxid;
    v.e_icr = e_icr; v.e_dcr = e_dcr;
    v.e_re = e_re; v.e_addr = e_addr; v.e_xid = e_xid;
    v.e_icv = e_icv; v.e_dcv = e_dcv;
    return v;
  endfunction

  task automatic idle_inputs();
    ic_bus.re = 1'b0; ic_bus.addr = '0; ic_bus.xid = '0;
    dc_bus.re = 1'b0; dc_bus.addr = '0; dc_bus.xid = '0;
    dram_ready = 1'b1; dram_valid = 1'b0; dram_xid = '0; dram_data = '0;
  endtask

  initial begin
    // Sequence from reset: counts 0/0, last grant DC.
    vt[0]  = mk(1, 23'h12345, 2, 1, 23'h00200, 1, 1, 0, 3'b000, 1, 0, 1, 23'h12345, 3'b010, 0, 0);
    vt[1]  = mk(1, 23'h00101, 1, 1, 23'h00201, 1, 1, 0, 3'b000, 0, 1, 1, 23'h00201, 3'b101, 0, 0);
    vt[2]  = mk(1, 23'h00102, 2, 1, 23'h00202, 2, 1, 0, 3'b000, 1, 0, 1, 23'h00102, 3'b010, 0, 0);
    vt[3]  = mk(1, 23'h00103, 3, 1, 23'h00203, 3, 1, 0, 3'b000, 0, 1, 1, 23'h00203, 3'b111, 0, 0);
    // Three stall cycles: slot full, dram_ready low.
    vt[4]  = mk(1, 23'h00104, 0, 1, 23'h00204, 0, 0, 0, 3'b000, 0, 0, 1, 23'h00203, 3'b111, 0, 0);
    vt[5]  = mk(1, 23'h00104, 0, 1, 23'h00204, 0, 0, 0, 3'b000, 0, 0, 1, 23'h00203, 3'b111, 0, 0);
    vt[6]  = mk(1, 23'h00104, 0, 1, 23'h00204, 0, 0, 0, 3'b000, 0, 0, 1, 23'h00203, 3'b111, 0, 0);
    vt[7]  = mk(1, 23'h00104, 0, 1, 23'h00204, 0, 1, 0, 3'b000, 1, 0, 1, 23'h00104, 3'b000, 0, 0);
    vt[8]  = mk(1, 23'h00105, 1, 0, 23'h00204, 0, 1, 0, 3'b000, 1, 0, 1, 23'h00105, 3'b001, 0, 0);
    // IC now at 4 outstanding: DC wins, then IC alone is refused.
    vt[9]  = mk(1, 23'h00106, 2, 1, 23'h00205, 1, 1, 0, 3'b000, 0, 1, 1, 23'h00205, 3'b101, 0, 0);
    vt[10] = mk(1, 23'h00106, 2, 0, 23'h00205, 1, 1, 1, 3'b001, 0, 0, 0, 23'h00205, 3'b101, 1, 0);
    vt[11] = mk(1, 23'h00106, 2, 0, 23'h00205, 1, 1, 0, 3'b000, 1, 0, 1, 23'h00106, 3'b010, 0, 0);
    // DC accept with DC response in the same cycle: count stays 3.
    vt[12] = mk(0, 23'h00106, 2, 1, 23'h00206, 2, 1, 1, 3'b101, 0, 1, 1, 23'h00206, 3'b110, 0, 1);
    vt[13] = mk(0, 23'h00106, 2, 1, 23'h00207, 3, 1, 0, 3'b000, 0, 1, 1, 23'h00207, 3'b111, 0, 0);
    vt[14] = mk(1, 23'h00107, 0, 1, 23'h00208, 0, 1, 0, 3'b000, 0, 0, 0, 23'h00207, 3'b111, 0, 0);

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst arb_re", 128'(arb_re), 128'd0);
    chk("rst arb_addr", 128'(arb_addr), 128'd0);
    chk("rst arb_xid", 128'(arb_xid), 128'd0);
    chk("rst arb_err", 128'(arb_err), 128'd0);
    chk("rst ic_valid", 128'(ic_bus.rsp_valid), 128'd0);
    chk("rst dc_data", dc_bus.rsp_data, 128'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      ic_bus.re = vt[i].ic_re; ic_bus.addr = vt[i].ic_addr; ic_bus.xid = vt[i].ic_xid;
      dc_bus.re = vt[i].dc_re; dc_bus.addr = vt[i].dc_addr; dc_bus.xid = vt[i].dc_xid;
      dram_ready = vt[i].drdy; dram_valid = vt[i].dval; dram_xid = vt[i].dxid;
      dram_data = DATA_T;
      #1;
      chk($sformatf("v%0d ic_ready", i), 128'(ic_bus.ready), 128'(vt[i].e_icr));
      chk($sformatf("v%0d dc_ready", i), 128'(dc_bus.ready), 128'(vt[i].e_dcr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d arb_re", i), 128'(arb_re), 128'(vt[i].e_re));
      if (vt[i].e_re) begin
        chk($sformatf("v%0d arb_addr", i), 128'(arb_addr), 128'(vt[i].e_addr));
        chk($sformatf("v%0d arb_xid", i), 128'(arb_xid), 128'(vt[i].e_xid));
      end
      chk($sformatf("v%0d ic_valid", i), 128'(ic_bus.rsp_valid), 128'(vt[i].e_icv));
      chk($sformatf("v%0d dc_valid", i), 128'(dc_bus.rsp_valid), 128'(vt[i].e_dcv));
      if (vt[i].e_icv) begin
        chk($sformatf("v%0d ic_xid", i), 128'(ic_bus.rsp_xid), 128'(vt[i].dxid[1:0]));
        chk($sformatf("v%0d ic_data", i), ic_bus.rsp_data, DATA_T);
      end
      chk($sformatf("v%0d arb_err", i), 128'(arb_err), 128'd0);
    end

    // DC response routing with a distinct line; IC registers must hold.
    @(negedge clk);
    idle_inputs();
    dram_valid = 1'b1; dram_xid = 3'b101; dram_data = DATA_A;
    @(posedge clk);
    #1;
    chk("rsp dc_valid", 128'(dc_bus.rsp_valid), 128'd1);
    chk("rsp dc_xid", 128'(dc_bus.rsp_xid), 128'd1);
    chk("rsp dc_data", dc_bus.rsp_data, DATA_A);
    chk("rsp ic_valid", 128'(ic_bus.rsp_valid), 128'd0);
    chk("rsp ic_data hold", ic_bus.rsp_data, DATA_T);
    @(negedge clk);
    idle_inputs();
    dc_bus.re = 1'b1; dc_bus.addr = 23'h00300; dc_bus.xid = 2'd0;
    #1;
    chk("dc credit back", 128'(dc_bus.ready), 128'd1);
    @(posedge clk);
    #1;
    chk("rsp dc_valid pulse", 128'(dc_bus.rsp_valid), 128'd0);

    // Stray response with IC count 0 after reset sets the sticky error.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    dram_valid = 1'b1; dram_xid = 3'b000;
    @(posedge clk);
    #1;
    chk("err set", 128'(arb_err), 128'd1);
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    chk("err sticky", 128'(arb_err), 128'd1);

    // Build a stall, then reset in the middle of it.
    @(negedge clk);
    ic_bus.re = 1'b1; ic_bus.addr = 23'h3ABCD; ic_bus.xid = 2'd1; dram_ready = 1'b0;
    #1;
    chk("stall ic_ready", 128'(ic_bus.ready), 128'd1);
    @(posedge clk);
    #1;
    chk("stall arb_re", 128'(arb_re), 128'd1);
    @(negedge clk);
    ic_bus.re = 1'b0;
    @(posedge clk);
    #1;
    chk("stall arb_addr", 128'(arb_addr), 128'h3ABCD);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst arb_re", 128'(arb_re), 128'd0);
    chk("midrst arb_addr", 128'(arb_addr), 128'd0);
    chk("midrst arb_xid", 128'(arb_xid), 128'd0);
    chk("midrst arb_err", 128'(arb_err), 128'd0);
    chk("midrst ic_ready", 128'(ic_bus.ready), 128'd0);
    chk("midrst ic_data", ic_bus.rsp_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
